// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the future transmitter:
// FSM state encodings, the default bit period, and an even-parity helper.
package uart_pkg;

   // 50 MHz core clock / 115200 baud
   localparam int CLKS_PER_BIT_DEFAULT = 434;

   // Explicit state encodings so the transmitter decodes the same values
   localparam logic [2:0] ENC_IDLE   = 3'd0;
   localparam logic [2:0] ENC_START  = 3'd1;
   localparam logic [2:0] ENC_DATA   = 3'd2;
   localparam logic [2:0] ENC_PARITY = 3'd3;
   localparam logic [2:0] ENC_STOP   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = ENC_IDLE,
      ST_START  = ENC_START,
      ST_DATA   = ENC_DATA,
      ST_PARITY = ENC_PARITY,
      ST_STOP   = ENC_STOP
   } uart_state_e;

   // Even parity bit for a byte: the value that makes the total number of ones even
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. The head entry is held in a register (dout)
// that is refreshed by a registered read of the storage array, with a bypass
// for the case where the entry written this cycle becomes the new head.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_inc;
   logic [CNT_W-1:0] count_reg;
   logic [WIDTH-1:0] head_reg;
   logic             push_eff;
   logic             pop_eff;

   assign full       = (count_reg == CNT_W'(DEPTH));
   assign empty      = (count_reg == '0);
   assign count      = count_reg;
   assign dout       = head_reg;
   assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

   // A full FIFO still accepts a push when a pop frees a slot in the same cycle
   assign pop_eff  = pop && !empty;
   assign push_eff = push && (!full || pop_eff);

   // Storage array, no reset needed: only the head register is visible
   always_ff @(posedge clk) begin
      if (push_eff) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointers, occupancy and the show-ahead head register
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         if (push_eff) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop_eff) begin
            rd_ptr_reg <= rd_ptr_inc;
         end
         case ({push_eff, pop_eff})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         if (pop_eff) begin
            // Next head is the written byte only when it lands right behind the popped one
            head_reg <= (count_reg == CNT_W'(1) && push_eff) ? din : mem[rd_ptr_inc];
         end else if (push_eff && empty) begin
            head_reg <= din;
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) feeding a show-ahead byte FIFO, with sticky overrun
// and framing error flags. Defining UART_RX_PARITY_EN adds an even-parity
// bit between the data bits and the stop bit, plus a sticky parity_err flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       uart_rdreq,
   input  logic       err_clr,
   output logic       uart_empty,
   output logic [7:0] uart_in,
   output logic       overrun,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       frame_err
);

   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]        sync_reg;
   logic              line;
   uart_state_e       state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [2:0]        bit_idx_reg;
   logic [7:0]        shift_reg;
   logic              stop_sample;
   logic              parity_ok;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FCNT_W-1:0] fifo_count;

   // Two-flop synchronizer; resets to the idle (high) line level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rxd};
      end
   end

   assign line        = sync_reg[1];
   assign stop_sample = (state_reg == ST_STOP) && (cnt_reg == '0);

`ifdef UART_RX_PARITY_EN
   logic parity_bit_reg;
   assign parity_ok = (even_parity(shift_reg) == parity_bit_reg);
`else
   assign parity_ok = 1'b1;
`endif

   assign push = stop_sample && line && parity_ok;
   assign pop  = uart_rdreq && !fifo_empty;

   // Frame decoder: half-bit delay to the start-bit centre, then one bit period per sample
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
         parity_bit_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (!line) begin
                  state_reg <= ST_START;
                  cnt_reg   <= HALF_LAST;
               end
            end
            ST_START: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end else if (!line) begin
                  state_reg   <= ST_DATA;
                  cnt_reg     <= BIT_LAST;
                  bit_idx_reg <= '0;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end else begin
                  shift_reg   <= {line, shift_reg[7:1]};
                  cnt_reg     <= BIT_LAST;
                  bit_idx_reg <= bit_idx_reg + 3'd1;
                  if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_reg <= ST_PARITY;
`else
                     state_reg <= ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end else begin
                  parity_bit_reg <= line;
                  cnt_reg        <= BIT_LAST;
                  state_reg      <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   // Sticky error flags: a new error in the same cycle as err_clr keeps the flag set
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         if (push && fifo_full && !uart_rdreq) begin
            overrun <= 1'b1;
         end else if (err_clr) begin
            overrun <= 1'b0;
         end
         if (stop_sample && !line) begin
            frame_err <= 1'b1;
         end else if (err_clr) begin
            frame_err <= 1'b0;
         end
`ifdef UART_RX_PARITY_EN
         if (stop_sample && !parity_ok) begin
            parity_err <= 1'b1;
         end else if (err_clr) begin
            parity_err <= 1'b0;
         end
`endif
      end
   end

   assign uart_empty = (fifo_count == '0);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (shift_reg),
      .dout  (uart_in),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=8, FIFO_DEPTH=4.
// Build with UART_RX_PARITY_EN defined to also exercise the parity option.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_LAT = 87;
`else
   localparam int FRAME_LAT = 79;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic       uart_rdreq;
   logic       err_clr;
   logic       uart_empty;
   logic [7:0] uart_in;
   logic       overrun;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc;
   int fall_cyc = -1;
   logic empty_q = 1'b1;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .uart_rdreq (uart_rdreq),
      .err_clr    (err_clr),
      .uart_empty (uart_empty),
      .uart_in    (uart_in),
      .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record the cycle on which uart_empty falls
   always @(negedge clk) begin
      if (empty_q === 1'b1 && uart_empty === 1'b0) fall_cyc = cyc;
      empty_q = uart_empty;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop_one();
      uart_rdreq = 1'b1;
      tick(1);
      uart_rdreq = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
   endtask

   // One serial frame; optional rdreq timed to land on the stop-bit sample cycle
   task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                             input logic par_good, input logic pop_at_stop);
      start_cyc = cyc;
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         tick(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^data) ^ ~par_good;
      tick(CPB);
`endif
      rxd = stop_bit;
      for (int j = 0; j < CPB; j++) begin
         uart_rdreq = pop_at_stop && (j == CPB - 2);
         tick(1);
      end
      uart_rdreq = 1'b0;
      rxd = 1'b1;
      $display("frame data=%02h stop=%0b par_good=%0b pop=%0b", data, stop_bit, par_good, pop_at_stop);
   endtask

   initial begin
      rst = 1'b1; rxd = 1'b1; uart_rdreq = 1'b0; err_clr = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(2);
      check("rst_empty",   32'(uart_empty), 32'd1);
      check("rst_uart_in", 32'(uart_in),    32'h00);
      check("rst_overrun", 32'(overrun),    32'd0);
      check("rst_frame",   32'(frame_err),  32'd0);

      // Single byte, latency from start-bit edge to uart_empty falling
      fall_cyc = -1;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      check("a5_latency", 32'(fall_cyc - start_cyc), 32'(FRAME_LAT));
      check("a5_data",    32'(uart_in), 32'hA5);
      pop_one();
      check("a5_empty_after_pop", 32'(uart_empty), 32'd1);

      // Short low glitch on the idle line is rejected
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(20);
      check("glitch_state",   32'(dut.state_reg), 32'(ST_IDLE));
      check("glitch_empty",   32'(uart_empty), 32'd1);
      check("glitch_overrun", 32'(overrun),    32'd0);
      check("glitch_frame",   32'(frame_err),  32'd0);

      // Five back-to-back bytes into a 4-deep FIFO, no reads: fifth dropped
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b1, 1'b0);
      tick(2);
      check("ovr_flag", 32'(overrun), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovr_head%0d", k), 32'(uart_in), 32'(k));
         pop_one();
      end
      check("ovr_drained", 32'(uart_empty), 32'd1);
      pulse_clr();
      check("ovr_cleared", 32'(overrun), 32'd0);

      // Same burst with a read coincident with the fifth push: nothing lost
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b1, b == 5);
      tick(2);
      check("pp_overrun", 32'(overrun), 32'd0);
      for (int k = 2; k <= 5; k++) begin
         check($sformatf("pp_head%0d", k), 32'(uart_in), 32'(k));
         pop_one();
      end
      check("pp_drained", 32'(uart_empty), 32'd1);

      // Stop bit low: byte discarded, frame_err sticky until err_clr
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      tick(12);
      check("fe_flag",  32'(frame_err),  32'd1);
      check("fe_empty", 32'(uart_empty), 32'd1);
      pulse_clr();
      check("fe_cleared", 32'(frame_err), 32'd0);

      // Reset after four data bits abandons the partial byte
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) tick(CPB);
      rst = 1'b1;
      tick(2);
      rxd = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(10);
      check("mid_rst_empty", 32'(uart_empty), 32'd1);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
      tick(2);
      check("mid_rst_data", 32'(uart_in), 32'h3C);
      pop_one();
      check("mid_rst_only_one", 32'(uart_empty), 32'd1);

`ifdef UART_RX_PARITY_EN
      // 8'h07 has three ones, so even parity requires a parity bit of 1
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      tick(2);
      check("par_bad_empty", 32'(uart_empty), 32'd1);
      check("par_bad_flag",  32'(parity_err), 32'd1);
      check("par_bad_frame", 32'(frame_err),  32'd0);
      pulse_clr();
      check("par_cleared", 32'(parity_err), 32'd0);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      tick(2);
      check("par_good_data", 32'(uart_in),    32'h07);
      check("par_good_flag", 32'(parity_err), 32'd0);
      pop_one();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200); legal range >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning received-byte buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  core clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1 framing.
REQ-006 SHALL have port uart_rdreq  input  1  pop request from core memory stage.
REQ-007 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-008 SHALL have port uart_empty  output  1  high when the FIFO holds no bytes.
REQ-009 SHALL have port uart_in  output  8  head-of-FIFO byte (show-ahead), valid while uart_empty is low.
REQ-010 SHALL have port overrun  output  1  sticky: byte dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  output  1  sticky: stop bit sampled low.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer before any use; both flops initialise to 1.
REQ-013 SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-027).
REQ-014 SHALL leave IDLE for START on the synchronized line being low; the bit counter loads CLKS_PER_BIT/2-1 (integer division).
REQ-015 SHALL, in START at counter zero, go to DATA if line is low, else return to IDLE (glitch reject), with no push and no flag.
REQ-016 SHALL, in DATA, sample every CLKS_PER_BIT cycles at bit centre, shifting LSB first; after the 8th sample go to STOP.
REQ-017 SHALL, in STOP at bit centre, push the byte if line is high, else discard it and set frame_err; either way return to IDLE the next cycle, so back-to-back frames are accepted.
REQ-018 SHALL present a pushed byte on uart_in with uart_empty low on the cycle after the stop-bit sample (latency 1).
REQ-019 SHALL pop on uart_rdreq high while uart_empty is low; uart_in shows the next entry on the following cycle; uart_rdreq while empty is ignored.
REQ-020 SHALL, on push and pop in the same cycle with the FIFO full, perform both, leaving the count unchanged and overrun clear.
REQ-021 SHALL, on push with the FIFO full and no pop, drop the new byte, keep the FIFO contents, and set overrun.
REQ-022 SHALL use log2(FIFO_DEPTH)-bit read/write pointers that wrap modulo FIFO_DEPTH, and a count of log2(FIFO_DEPTH)+1 bits.
REQ-023 SHALL clear overrun and frame_err on err_clr; a set event in the same cycle as err_clr wins, and the flag stays high.

Reset
REQ-024 SHALL, on rst, force state IDLE, counters 0, pointers and count 0, uart_empty=1, uart_in=8'h00, overrun=0, frame_err=0, and synchronizer flops to 1.
REQ-025 SHALL, when rst is asserted mid-frame, abandon the partial byte; the first frame is decoded only from a falling edge seen after rst deasserts.
REQ-026 SHALL not require FIFO storage contents to be reset; only uart_in visibility is defined.

Configuration
REQ-027 SHALL, with UART_RX_PARITY_EN defined, insert a PARITY state between DATA and STOP that samples one even-parity bit and add output parity_err  1  sticky (cleared by err_clr); a parity mismatch discards the byte at STOP and sets parity_err.
REQ-028 SHALL, without UART_RX_PARITY_EN, have no PARITY state and no parity_err port, with 8N1 behaviour exactly as in REQ-013..REQ-017.

Structure
REQ-029 SHALL take its state encoding localparams and the default CLKS_PER_BIT from shared package uart_pkg, which the future transmitter also uses.
REQ-030 SHALL instantiate the buffer as one sub-module, sync_fifo (parameterised width/depth, show-ahead, push/pop/full/empty/count).

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-031 SHALL cover: send 8'hA5 8N1 -> uart_empty falls 1 cycle after the stop sample, uart_in=8'hA5; one rdreq -> uart_empty=1.
REQ-032 SHALL cover: a 3-cycle low glitch on idle rxd -> no push, no flags, and state returns to IDLE.
REQ-033 SHALL cover: 5 back-to-back bytes 8'h01..8'h05 with no rdreq -> FIFO holds 01..04, overrun=1; with rdreq coincident with the 5th push -> holds 02..05, overrun=0.
REQ-034 SHALL cover: a frame with the stop bit low -> no push, frame_err=1; err_clr pulse -> frame_err=0.
REQ-035 SHALL cover: rst asserted after 4 data bits, then 8'h3C sent -> only 8'h3C is received.
REQ-036 SHALL cover (UART_RX_PARITY_EN): 8'h07 with parity bit 0 -> dropped, parity_err=1; with parity bit 1 -> received.
